// File: rtl/common_fifo_pkg.sv
// Shared definitions for the common FIFO family.
//   count_width() : width of an occupancy counter able to hold 0..depth
//   acc_cnt_e     : encoded number of accepted pops / writes in a cycle
//   slot_sel_e    : per-slot next-value select driven by the FIFO top level
package common_fifo_pkg;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ONE  = 2'd1,
    ACC_TWO  = 2'd2
  } acc_cnt_e;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_SHIFT1 = 3'd1,
    SEL_SHIFT2 = 3'd2,
    SEL_DIN0   = 3'd3,
    SEL_DIN1   = 3'd4
  } slot_sel_e;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/common_fifo_shift_entry.sv
// One storage slot of the shifting FIFO.
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset (loads RESET_VALUE)
//   sel          : next-value select (hold / shift by 1 / shift by 2 / din0 / din1)
//   shift1_data  : contents of the slot one position further from the head
//   shift2_data  : contents of the slot two positions further from the head
//   din0, din1   : write data
//   q            : registered slot contents
module common_fifo_shift_entry
  import common_fifo_pkg::*;
#(
  parameter int               WIDTH       = 6,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  slot_sel_e        sel,
  input  logic [WIDTH-1:0] shift1_data,
  input  logic [WIDTH-1:0] shift2_data,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= RESET_VALUE;
    end else begin
      unique case (sel)
        SEL_SHIFT1: q <= shift1_data;
        SEL_SHIFT2: q <= shift2_data;
        SEL_DIN0:   q <= din0;
        SEL_DIN1:   q <= din1;
        default:    q <= q;
      endcase
    end
  end

endmodule

// File: rtl/common_fifo_shift_2w2r.sv
// Shifting FIFO with two write and two read ports per cycle. Entry 0 is the
// head; pops shift the remaining entries toward the head, writes land directly
// behind the surviving entries.
// Ports:
//   clk, resetn            : clock, asynchronous active-low reset
//   din0/din1, wen0/wen1   : write data / requests (din0 is older; wen1 needs wen0)
//   ren0/ren1              : pop requests (ren1 needs ren0)
//   dout0/dout1            : entry 0 / entry 1, combinational from registers
//   fifo_empty/fifo_full   : occupancy flags
//   fifo_count             : occupancy
//   fifo_error             : only with COMMON_FIFO_SHIFT_2W2R_ERROR_EN defined;
//                            sticky flag set by any rejected request
module common_fifo_shift_2w2r
  import common_fifo_pkg::*;
#(
  parameter int                                 FIFO_DEPTH       = 16,
  parameter int                                 FIFO_WIDTH       = 6,
  parameter int                                 FIFO_RESET_STATE = 0,
  parameter logic [FIFO_DEPTH*FIFO_WIDTH-1:0]   FIFO_RESET_VALUE = '0
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [FIFO_WIDTH-1:0]             din0,
  input  logic [FIFO_WIDTH-1:0]             din1,
  input  logic                              wen0,
  input  logic                              wen1,
  input  logic                              ren0,
  input  logic                              ren1,
  output logic [FIFO_WIDTH-1:0]             dout0,
  output logic [FIFO_WIDTH-1:0]             dout1,
  output logic                              fifo_empty,
  output logic                              fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
`ifdef COMMON_FIFO_SHIFT_2W2R_ERROR_EN
  ,
  output logic                              fifo_error
`endif
);

  localparam int CW = count_width(FIFO_DEPTH);

  logic [CW-1:0]         count_q;
  acc_cnt_e              r_acc;
  acc_cnt_e              w_acc;
  int                    cnt;
  int                    free_slots;
  int                    r_num;
  int                    w_num;
  int                    keep_cnt;
  slot_sel_e             slot_sel [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] entry_q  [FIFO_DEPTH];

  // Accept counts are judged against occupancy at the start of the cycle, so
  // a pop never frees room for a same-cycle write.
  always_comb begin
    cnt        = int'(count_q);
    free_slots = FIFO_DEPTH - cnt;

    r_acc = ACC_TWO;
    if (!ren0 || cnt == 0)       r_acc = ACC_NONE;
    else if (!ren1 || cnt == 1)  r_acc = ACC_ONE;

    w_acc = ACC_TWO;
    if (!wen0 || free_slots == 0)       w_acc = ACC_NONE;
    else if (!wen1 || free_slots == 1)  w_acc = ACC_ONE;

    r_num    = int'(r_acc);
    w_num    = int'(w_acc);
    keep_cnt = cnt - r_num;
  end

  // Surviving entries move toward the head by r_num; new data lands right
  // behind them. Slots beyond the new occupancy simply hold.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot_sel[i] = SEL_HOLD;
      if (i < keep_cnt) begin
        if (r_num == 2)      slot_sel[i] = SEL_SHIFT2;
        else if (r_num == 1) slot_sel[i] = SEL_SHIFT1;
      end else if (i == keep_cnt && w_num >= 1) begin
        slot_sel[i] = SEL_DIN0;
      end else if (i == keep_cnt + 1 && w_num == 2) begin
        slot_sel[i] = SEL_DIN1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= CW'(FIFO_RESET_STATE);
    end else begin
      count_q <= CW'(cnt - r_num + w_num);
    end
  end

  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_slot
    logic [FIFO_WIDTH-1:0] sh1;
    logic [FIFO_WIDTH-1:0] sh2;

    // Tail slots have no upstream neighbour; these inputs are never selected.
    if (i + 1 < FIFO_DEPTH) begin : g_sh1
      assign sh1 = entry_q[i+1];
    end else begin : g_sh1_tie
      assign sh1 = '0;
    end
    if (i + 2 < FIFO_DEPTH) begin : g_sh2
      assign sh2 = entry_q[i+2];
    end else begin : g_sh2_tie
      assign sh2 = '0;
    end

    common_fifo_shift_entry #(
      .WIDTH       (FIFO_WIDTH),
      .RESET_VALUE (FIFO_RESET_VALUE[i*FIFO_WIDTH +: FIFO_WIDTH])
    ) u_entry (
      .clk         (clk),
      .resetn      (resetn),
      .sel         (slot_sel[i]),
      .shift1_data (sh1),
      .shift2_data (sh2),
      .din0        (din0),
      .din1        (din1),
      .q           (entry_q[i])
    );
  end

  assign dout0      = entry_q[0];
  assign dout1      = entry_q[1];
  assign fifo_count = count_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

`ifdef COMMON_FIFO_SHIFT_2W2R_ERROR_EN
  logic reject;

  assign reject = (ren0 && r_acc == ACC_NONE) || (ren1 && r_acc != ACC_TWO) ||
                  (wen0 && w_acc == ACC_NONE) || (wen1 && w_acc != ACC_TWO);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fifo_error <= 1'b0;
    end else if (reject) begin
      fifo_error <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/common_fifo_shift_2w2r.md
COMMON_FIFO_SHIFT_2W2R -- requirements
Module: common_fifo_shift_2w2r

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: entry count, at least 2.
REQ-002 SHALL have parameter FIFO_WIDTH, default 6: bits per entry.
REQ-003 SHALL have parameter FIFO_RESET_STATE, default 0: occupancy after reset, 0..FIFO_DEPTH.
REQ-004 SHALL have parameter FIFO_RESET_VALUE, default all-zero, FIFO_DEPTH*FIFO_WIDTH bits: entry i reset to bits [i*FIFO_WIDTH +: FIFO_WIDTH]; entry 0 is head.
REQ-005 SHALL have ports: clk in 1, single clock, rising edge.
REQ-006 resetn in 1: reset, asynchronous, active-low.
REQ-007 din0/din1 in FIFO_WIDTH each: write data; din0 older. wen0/wen1 in 1 each: write requests.
REQ-008 dout0/dout1 out FIFO_WIDTH each: entry 0 (head) / entry 1. ren0/ren1 in 1 each: pop requests.
REQ-009 fifo_empty out 1 (count==0); fifo_full out 1 (count==FIFO_DEPTH); fifo_count out $clog2(FIFO_DEPTH+1): occupancy.

Function
REQ-010 SHALL accept R pops per cycle: 0 if !ren0 or count==0; 1 if ren0 and (!ren1 or count==1); else 2. ren1 without ren0 is ignored.
REQ-011 SHALL accept W writes: 0 if !wen0 or free==0; 1 if wen0 and (!wen1 or free==1); else 2. free = FIFO_DEPTH-count at cycle start; same-cycle pops never create space (full + pop + push writes nothing). wen1 without wen0 is ignored.
REQ-012 Next state: entry[i] <= entry[i+R] for i < count-R; entry[count-R] <= din0 if W>=1; entry[count-R+1] <= din1 if W==2; count <= count-R+W.
REQ-013 Pop-and-write to empty FIFO: pops rejected; writes land at entry 0/1.
REQ-014 dout0/dout1 SHALL be driven combinationally from registered entries; zero-latency read, one-cycle write-to-visible latency. Contents of entries at index >= count are unspecified; benches SHALL NOT check them.
REQ-015 fifo_empty, fifo_full, fifo_count SHALL depend only on the count register.
REQ-016 Rejected requests SHALL not alter state; no wrap-around, count saturates only by REQ-010/011.

Reset
REQ-017 On resetn low, immediately: count = FIFO_RESET_STATE; entry i = FIFO_RESET_VALUE slice i for all i; outputs follow REQ-008/009.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight requests; first accepted operation occurs on the first rising clk after resetn deasserts.

Configuration
REQ-019 Macro COMMON_FIFO_SHIFT_2W2R_ERROR_EN: when defined, adds output fifo_error (1 bit, reset 0), set sticky on any cycle with a rejected wen0/wen1/ren0/ren1 (REQ-010/011), cleared only by reset.
REQ-020 When undefined, fifo_error port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-021 Shared package common_fifo_pkg SHALL hold the count-width function and the 2-bit accept-count encoding (NONE, ONE, TWO) used by R and W.
REQ-022 One sub-module common_fifo_shift_entry SHALL implement a single slot: reset value, hold, shift-by-1, shift-by-2, load din0, load din1 selected by encoded control.
REQ-023 Top level SHALL contain count register, accept logic, and per-slot select generation only.

Verification (FIFO_DEPTH=8, FIFO_WIDTH=6, FIFO_RESET_STATE=4, reset values entry i = i)
REQ-024 Release reset -> fifo_count=4, dout0=0, dout1=1, fifo_empty=0, fifo_full=0.
REQ-025 ren0=ren1=1, wen0=wen1=1 din0=10 din1=11 -> next cycle count=4, dout0=2, dout1=3; entries 2..3 = 10,11.
REQ-026 From count=7, wen0=wen1=1 din0=20 din1=21 -> count=8, fifo_full=1, entry 7=20, 21 dropped; fifo_error=1 when ERROR_EN defined.
REQ-027 Full, ren0=1, wen0=1 -> count=7, write rejected, dout0 = old entry 1.
REQ-028 Count=1, ren0=ren1=1 -> count=0, fifo_empty=1; further ren0 leaves count=0.
REQ-029 Assert resetn low mid-cycle after REQ-025 traffic -> outputs return to REQ-024 values without a clock edge.
